// File: rtl/sa_fifo_pkg.sv
// rtl/sa_fifo_pkg.sv - shared sizes, types and helpers for the 128x18 FIFO controller
// Purpose: geometry constants, data/pointer types and the mod-3 index helper
// used by the controller and its output prefetch buffer.
package sa_fifo_pkg;
    localparam int SA_FIFO_DEPTH = 128;
    localparam int SA_FIFO_WIDTH = 18;
    localparam int SA_FIFO_AW    = 7;
    localparam int SA_FIFO_OBUF  = 3;
    localparam int SA_FIFO_CW    = 8;

    typedef logic [SA_FIFO_WIDTH-1:0] sa_fifo_data_t;
    typedef logic [SA_FIFO_AW-1:0]    sa_fifo_ptr_t;
    typedef logic [SA_FIFO_CW-1:0]    sa_fifo_cnt_t;

    // Output buffer has 3 slots, so its indices wrap at 2 rather than at a power of two.
    function automatic logic [1:0] obuf_inc(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction
endpackage

// File: rtl/sa_fifo_obuf3.sv
// rtl/sa_fifo_obuf3.sv - 3-entry circular prefetch buffer in front of the read stream
// Purpose: absorbs words landing from the RAM and presents the head word.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   land_i/land_data_i  write a landed RAM word at the tail
//   pop_i               consumer took the head word (already qualified by cnt_o != 0)
//   head_data_o         word at the head
//   cnt_o, cnt_nxt_o    current occupancy and occupancy after this cycle
module sa_fifo_obuf3
    import sa_fifo_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          land_i,
    input  sa_fifo_data_t land_data_i,
    input  logic          pop_i,
    output sa_fifo_data_t head_data_o,
    output logic [1:0]    cnt_o,
    output logic [1:0]    cnt_nxt_o
);
    sa_fifo_data_t mem_q [SA_FIFO_OBUF];
    logic [1:0]    head_q, head_d;
    logic [1:0]    tail_q, tail_d;
    logic [1:0]    cnt_q,  cnt_d;

    always_comb begin
        head_d = pop_i  ? obuf_inc(head_q) : head_q;
        tail_d = land_i ? obuf_inc(tail_q) : tail_q;
        // Land and pop together leave the count unchanged while both indices move.
        cnt_d  = cnt_q + {1'b0, land_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= 2'd0;
            tail_q <= 2'd0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is not reset; a word landing during reset is discarded by the cleared count.
    always_ff @(posedge clk_i) begin
        if (land_i) begin
            mem_q[tail_q] <= land_data_i;
        end
    end

    assign head_data_o = mem_q[head_q];
    assign cnt_o       = cnt_q;
    assign cnt_nxt_o   = rst_i ? 2'd0 : cnt_d;

    a_obuf_no_overflow:  assert property (@(posedge clk_i) disable iff (rst_i)
                                          !(land_i && !pop_i && cnt_q == 2'd3));
    a_obuf_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                          !(pop_i && cnt_q == 2'd0));
    a_obuf_cnt_range:    assert property (@(posedge clk_i) disable iff (rst_i)
                                          cnt_q <= 2'd3);
endmodule

// File: rtl/sa_fifo_ctrl_128x18.sv
// rtl/sa_fifo_ctrl_128x18.sv - 128x18 synchronous FIFO controller driving an external RAM macro
// Purpose: valid/ready write and read streams over a 1-cycle-latency RAM, with a
// 3-entry prefetch buffer so reads stream at one word per cycle.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_data    write stream
//   rd_valid/rd_ready/rd_data    read stream
//   count                        entries held (RAM + in flight + output buffer), 0..131
//   ram_wa/ram_we/ram_di         RAM write port
//   ram_ra/ram_re/ram_dout       RAM read port, data valid the cycle after ram_re
//   pwrbus_ram_pd                RAM power-down bus, tied off
module sa_fifo_ctrl_128x18
    import sa_fifo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [17:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [17:0] rd_data,
    output logic [7:0]  count,
    output logic [6:0]  ram_wa,
    output logic        ram_we,
    output logic [17:0] ram_di,
    output logic [6:0]  ram_ra,
    output logic        ram_re,
    input  logic [17:0] ram_dout,
    output logic [31:0] pwrbus_ram_pd
);
    sa_fifo_ptr_t wptr_q, wptr_d;
    sa_fifo_ptr_t rptr_q, rptr_d;
    sa_fifo_cnt_t ram_cnt_q, ram_cnt_d;
    sa_fifo_cnt_t count_q, count_d;
    logic         inflight_q;
    logic [1:0]   obuf_cnt, obuf_cnt_nxt;
    logic         push, issue, pop;

    assign wr_ready = (ram_cnt_q != 8'(SA_FIFO_DEPTH));
    assign push     = wr_valid & wr_ready & ~rst;
    // Issue looks only at registered state; a pop this cycle frees a slot for next cycle.
    assign issue    = (ram_cnt_q != 8'd0)
                    & ((3'(obuf_cnt) + 3'(inflight_q)) < 3'(SA_FIFO_OBUF))
                    & ~rst;
    assign pop      = rd_valid & rd_ready;

    always_comb begin
        wptr_d  = wptr_q + 7'(push);
        rptr_d  = rptr_q + 7'(issue);
        unique case ({push, issue})
            2'b10:   ram_cnt_d = ram_cnt_q + 8'd1;
            2'b01:   ram_cnt_d = ram_cnt_q - 8'd1;
            default: ram_cnt_d = ram_cnt_q;
        endcase
        count_d = ram_cnt_d + 8'(issue) + 8'(obuf_cnt_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= issue;
            count_q    <= count_d;
        end
    end

    sa_fifo_obuf3 u_obuf (
        .clk_i       (clk),
        .rst_i       (rst),
        .land_i      (inflight_q),
        .land_data_i (ram_dout),
        .pop_i       (pop),
        .head_data_o (rd_data),
        .cnt_o       (obuf_cnt),
        .cnt_nxt_o   (obuf_cnt_nxt)
    );

    assign rd_valid      = (obuf_cnt != 2'd0);
    assign count         = count_q;
    assign ram_we        = push;
    assign ram_wa        = wptr_q;
    assign ram_di        = wr_data;
    assign ram_re        = issue;
    assign ram_ra        = rptr_q;
    assign pwrbus_ram_pd = '0;

    a_ram_cnt_range: assert property (@(posedge clk) disable iff (rst)
                                      ram_cnt_q <= 8'(SA_FIFO_DEPTH));
    a_count_range:   assert property (@(posedge clk) disable iff (rst)
                                      count_q <= 8'(SA_FIFO_DEPTH + SA_FIFO_OBUF));
    a_no_push_full:  assert property (@(posedge clk) disable iff (rst)
                                      !(push && ram_cnt_q == 8'(SA_FIFO_DEPTH)));
endmodule

// File: tb/tb_sa_fifo_ctrl_128x18.sv
// tb/tb_sa_fifo_ctrl_128x18.sv - randomized scoreboard bench for the 128x18 FIFO controller
module tb_sa_fifo_ctrl_128x18;
    logic        clk = 1'b0;
    logic        rst, wr_valid, wr_ready, rd_valid, rd_ready;
    logic [17:0] wr_data, rd_data, ram_di, ram_dout;
    logic [7:0]  count;
    logic [6:0]  ram_wa, ram_ra;
    logic        ram_we, ram_re;
    logic [31:0] pwrbus_ram_pd;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_pop = 0;
    logic [17:0] q[$];
    bit          hold_q = 1'b0;
    logic [17:0] ram_m [128];

    always #5 clk = ~clk;

    sa_fifo_ctrl_128x18 dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_dout(ram_dout),
        .pwrbus_ram_pd(pwrbus_ram_pd)
    );

    // RAM macro: registered read address, data appears the cycle after ram_re.
    always @(posedge clk) begin
        if (ram_we) ram_m[ram_wa] <= ram_di;
        if (ram_re) ram_dout <= ram_m[ram_ra];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: called at a negedge, drives inputs, updates the model, checks at next negedge.
    task automatic cyc(input logic wv, input logic [17:0] wd, input logic rr);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        if (hold_q) chk("rd_valid_hold", rd_valid, 1);
        if (rd_valid) begin
            chk("rd_valid_has_data", q.size() != 0, 1);
            if (q.size() != 0) chk("rd_data", rd_data, q[0]);
        end
        if (!wr_ready) chk("full_count", count >= 8'd128, 1);
        hold_q = rd_valid & !rr;
        if (wv && wr_ready) q.push_back(wd);
        if (rr && rd_valid) begin
            if (q.size() != 0) void'(q.pop_front());
            n_pop++;
        end
        @(negedge clk);
        chk("count", count, q.size());
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) cyc(1'b0, 18'h0, 1'b1);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_valid = 1'b1; wr_data = 18'h3FFFF; rd_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_pwrbus", pwrbus_ram_pd, 0);
        rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;

        // Empty-to-first-data latency
        cyc(1'b1, 18'h2AAAA, 1'b0);
        chk("lat_re_t1", ram_re, 1);
        chk("lat_valid_t1", rd_valid, 0);
        cyc(1'b0, 18'h0, 1'b0);
        chk("lat_valid_t2", rd_valid, 0);
        cyc(1'b0, 18'h0, 1'b0);
        chk("lat_valid_t3", rd_valid, 1);
        chk("lat_data_t3", rd_data, 18'h2AAAA);
        cyc(1'b0, 18'h0, 1'b1);
        chk("lat_empty", q.size(), 0);

        // Sustained streaming across pointer wrap
        n_pop = 0;
        for (int i = 0; i < 300; i++) cyc(1'b1, 18'(i + 'h100), 1'b1);
        chk("stream_pops", n_pop, 297);
        drain(20);

        // Fill to full with the consumer stalled
        for (int i = 0; i < 200 && wr_ready; i++) cyc(1'b1, 18'($urandom), 1'b0);
        chk("full_accepted", q.size(), 131);
        chk("full_count131", count, 131);
        chk("full_wr_ready", wr_ready, 0);
        cyc(1'b0, 18'h0, 1'b1);
        for (int w = 0; w < 2 && !wr_ready; w++) cyc(1'b0, 18'h0, 1'b0);
        chk("full_reassert", wr_ready, 1);

        // Backpressure hold with a full output buffer
        cyc(1'b0, 18'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("hold_re", ram_re, 0);
            chk("hold_valid", rd_valid, 1);
            cyc(1'b0, 18'h0, 1'b0);
        end
        drain(300);

        // Random traffic
        for (int i = 0; i < 10000; i++)
            cyc(1'($urandom % 2), 18'($urandom), 1'($urandom % 2));
        drain(300);

        // Reset with 57 entries and a read in flight
        for (int i = 0; i < 100 && q.size() < 58; i++) cyc(1'b1, 18'($urandom), 1'b0);
        cyc(1'b0, 18'h0, 1'b1);
        chk("pre_rst_re", ram_re, 1);
        cyc(1'b0, 18'h0, 1'b0);
        chk("pre_rst_count", count, 57);
        rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        q.delete();
        hold_q = 1'b0;
        chk("post_rst_rd_valid", rd_valid, 0);
        chk("post_rst_count", count, 0);
        chk("post_rst_wr_ready", wr_ready, 1);
        rst = 1'b0;
        cyc(1'b1, 18'h15555, 1'b0);
        begin
            int p0;
            p0 = n_pop;
            for (int i = 0; i < 6 && n_pop == p0; i++) cyc(1'b0, 18'h0, 1'b1);
            chk("post_rst_pop", n_pop - p0, 1);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 18'h0, 1'b1);
        chk("post_rst_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
